// File: rtl/tdc_pulse_fifo.sv
// tdc_pulse_fifo
//   Pulse-width / leading-edge timestamp digitizer with an internal
//   first-word-fall-through FIFO, drained by the readout arbiter.
//
//   Each high pulse on SIG becomes one 32-bit word:
//      [31:28] IDENTIFIER
//      [27:16] width in cycles (saturates at 0xFFF)
//      [15:0]  timestamp of the leading edge
//
// Ports
//   BUS_CLK     sole clock, rising edge
//   RSTn        synchronous active-low reset
//   EN          measurement enable (also gates the timestamp counter)
//   SIG         asynchronous discriminator input
//   FIFO_READ   pop strobe from the arbiter
//   FIFO_EMPTY  no word available
//   FIFO_FULL   FIFO holds DEPTH words
//   FIFO_DATA   head word, valid while FIFO_EMPTY=0 (zero when empty)
//   LOST_CNT    pulses dropped because the FIFO was full, saturating
//   BUSY        measurement FSM not idle
//
// State | meaning
// IDLE  | waiting for a synchronized rising edge with EN=1
// HIGH  | pulse in progress, width counting
// STORE | one cycle, pushes the packed word
module tdc_pulse_fifo #(
    parameter int         DEPTH      = 64,
    parameter logic [3:0] IDENTIFIER = 4'b0100
) (
    input  logic        BUS_CLK,
    input  logic        RSTn,
    input  logic        EN,
    input  logic        SIG,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic        FIFO_FULL,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_CNT,
    output logic        BUSY
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic          w_rise;
    logic          w_fall;

    logic [15:0]   r_ts;
    logic [15:0]   r_ts_le;
    logic [11:0]   r_width;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          r_empty;
    logic          r_full;
    logic [7:0]    r_lost;

    logic          w_push;
    logic          w_wr;
    logic          w_pop;
    logic          w_lost;
    logic [31:0]   w_word;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // ---------------------------------------------------------------
    // Synchronizer, timestamp and measurement registers
    // ---------------------------------------------------------------
    always_ff @(posedge BUS_CLK) begin
        if (!RSTn) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_ts    <= 16'd0;
            r_ts_le <= 16'd0;
            r_width <= 12'd0;
        end else begin
            r_s1 <= SIG;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (EN) begin
                r_ts <= r_ts + 16'd1;
            end
            if (EN && r_state == IDLE && w_rise) begin
                r_ts_le <= r_ts;
                r_width <= 12'd1;
            end else if (EN && r_state == HIGH && r_s2 && r_width != 12'hFFF) begin
                r_width <= r_width + 12'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge BUS_CLK) begin
        if (!RSTn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        if (!EN) begin
            // Dropping EN abandons any pulse in flight without counting it lost.
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_state_nxt = STORE;
                    end
                end
                STORE: begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign BUSY   = (r_state != IDLE);
    assign w_word = {IDENTIFIER, r_width, r_ts_le};

    // ---------------------------------------------------------------
    // FWFT FIFO
    // ---------------------------------------------------------------
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_pop  = FIFO_READ & ~r_empty;
    assign w_wr   = w_push & (~r_full | FIFO_READ);
    assign w_lost = w_push & ~w_wr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (RSTn && w_wr) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!RSTn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_lost  <= 8'd0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_MAX);
            if (w_lost && r_lost != 8'hFF) begin
                r_lost <= r_lost + 8'd1;
            end
        end
    end

    assign FIFO_EMPTY = r_empty;
    assign FIFO_FULL  = r_full;
    // The array is not reset, so the head is masked while empty.
    assign FIFO_DATA  = r_empty ? 32'd0 : r_mem[r_rptr];
    assign LOST_CNT   = r_lost;

endmodule

// File: tb/tb_tdc_pulse_fifo.sv
module tb_tdc_pulse_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        sig;
    logic        rd;
    logic        empty;
    logic        full;
    logic [31:0] data;
    logic [7:0]  lost;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    // Timestamp reference: counts edges with EN=1, cleared by reset.
    logic [15:0] ts_m;

    typedef struct {
        logic [15:0] ts;
        int          len;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    tdc_pulse_fifo #(
        .DEPTH      (4),
        .IDENTIFIER (4'b0100)
    ) dut (
        .BUS_CLK    (clk),
        .RSTn       (rstn),
        .EN         (en),
        .SIG        (sig),
        .FIFO_READ  (rd),
        .FIFO_EMPTY (empty),
        .FIFO_FULL  (full),
        .FIFO_DATA  (data),
        .LOST_CNT   (lost),
        .BUSY       (busy)
    );

    always @(posedge clk) begin
        if (!rstn)   ts_m <= 16'd0;
        else if (en) ts_m <= ts_m + 16'd1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_pulse(input int len);
        sig = 1'b1;
        step(len);
        sig = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    task automatic wait_ts(input logic [15:0] target);
        int i;
        for (i = 0; i < 70000; i++) begin
            if (ts_m == target) break;
            step(1);
        end
        if (i >= 70000) chk("wait_ts timeout", 32'(ts_m), 32'(target));
    endtask

    // Returns the number of edges until FIFO_EMPTY drops (bounded).
    task automatic wait_word(output int n);
        n = 0;
        while (empty && n < 20) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] w5;
        logic [31:0] w;
        int          lat;

        vecs[0] = '{16'h0020,   10, 32'h400A_0020};
        vecs[1] = '{16'h0040,    1, 32'h4001_0040};
        vecs[2] = '{16'h0100, 5000, 32'h4FFF_0100};
        vecs[3] = '{16'h2000,    3, 32'h4003_2000};
        vecs[4] = '{16'h3000, 4095, 32'h4FFF_3000};
        vecs[5] = '{16'h5000, 4094, 32'h4FFE_5000};
        vecs[6] = '{16'hFFFE,    4, 32'h4004_FFFE};
        vecs[7] = '{16'h0040,    2, 32'h4002_0040};

        rstn = 1'b0;
        en   = 1'b1;
        sig  = 1'b0;
        rd   = 1'b0;
        step(3);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full",  32'(full),  32'd0);
        chk("reset data",  data,       32'd0);
        chk("reset lost",  32'(lost),  32'd0);
        chk("reset busy",  32'(busy),  32'd0);
        rstn = 1'b1;

        // Single pulses: width, timestamp, latency, wrap.
        for (int v = 0; v < 8; v++) begin
            wait_ts(vecs[v].ts - 16'd2);
            drive_pulse(vecs[v].len);
            wait_word(lat);
            chk($sformatf("vec%0d latency", v), 32'(lat), 32'd4);
            chk($sformatf("vec%0d word", v), data, vecs[v].exp_word);
            pop();
            chk($sformatf("vec%0d empty after pop", v), 32'(empty), 32'd1);
        end

        // Overflow with DEPTH=4: six pulses, no reads.
        for (int p = 0; p < 6; p++) begin
            w = {4'h4, 12'd3, ts_m + 16'd2};
            if (p < 4) exp_q.push_back(w);
            drive_pulse(3);
            step(6);
            if (p == 3) chk("full after 4th", 32'(full), 32'd1);
        end
        chk("lost after 6", 32'(lost), 32'd2);
        chk("full after 6", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), data, exp_q[i]);
            pop();
        end
        chk("drained empty", 32'(empty), 32'd1);
        chk("drained full",  32'(full),  32'd0);

        // Pops while empty must not move the read pointer.
        rd = 1'b1;
        step(2);
        rd = 1'b0;
        chk("empty pop ignored", 32'(empty), 32'd1);

        // Refill, then pop in the STORE cycle while full.
        exp_q.delete();
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back({4'h4, 12'd3, ts_m + 16'd2});
            drive_pulse(3);
            step(6);
        end
        chk("refill full", 32'(full), 32'd1);
        w5 = {4'h4, 12'd3, ts_m + 16'd2};
        drive_pulse(3);
        step(3);
        chk("busy in store", 32'(busy), 32'd1);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        chk("full after swap", 32'(full), 32'd1);
        chk("lost after swap", 32'(lost), 32'd2);
        exp_q.push_back(w5);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("swap drain%0d", i), data, exp_q[i]);
            pop();
        end
        chk("swap drained empty", 32'(empty), 32'd1);

        // EN dropped mid-pulse, then re-enabled with SIG already high.
        sig = 1'b1;
        step(5);
        chk("busy mid pulse", 32'(busy), 32'd1);
        en = 1'b0;
        step(1);
        chk("busy after en drop", 32'(busy), 32'd0);
        step(4);
        sig = 1'b0;
        step(5);
        sig = 1'b1;
        step(5);
        en = 1'b1;
        step(5);
        chk("busy sig already high", 32'(busy), 32'd0);
        sig = 1'b0;
        step(8);
        chk("no word after en drop", 32'(empty), 32'd1);
        chk("lost after en drop", 32'(lost), 32'd2);
        w = {4'h4, 12'd2, ts_m + 16'd2};
        drive_pulse(2);
        wait_word(lat);
        chk("post-en word", data, w);
        pop();

        // Reset with three words buffered and a pulse in flight.
        for (int p = 0; p < 3; p++) begin
            drive_pulse(2);
            step(6);
        end
        chk("three buffered", 32'(empty), 32'd0);
        sig = 1'b1;
        step(4);
        rstn = 1'b0;
        sig  = 1'b0;
        step(1);
        rstn = 1'b1;
        chk("rst2 empty", 32'(empty), 32'd1);
        chk("rst2 full",  32'(full),  32'd0);
        chk("rst2 lost",  32'(lost),  32'd0);
        chk("rst2 busy",  32'(busy),  32'd0);
        chk("rst2 data",  data,       32'd0);
        drive_pulse(5);
        wait_word(lat);
        chk("post-reset word", data, 32'h4005_0002);
        pop();
        chk("post-reset single", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
